// File: rtl/xpb_sched_pkg.sv
// Shared definitions for the xpb reduction scheduler.
// Holds the digit and ROM word widths, the scheduler state type and a
// helper that sizes the accumulator so it cannot overflow.
package xpb_sched_pkg;

    localparam int DIGIT_W = 5;
    localparam int WORD_W  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Summing num_digits WORD_W-bit entries needs $clog2(num_digits) extra bits
    function automatic int acc_w(input int num_digits);
        return WORD_W + $clog2(num_digits);
    endfunction

endpackage

// File: rtl/xpb_next_digit.sv
// Priority encoder over the remaining-digit mask: returns the lowest set
// position and flags an empty mask. Used only when zero-digit skipping
// (XPB_SKIP_ZERO_EN) is enabled in the scheduler.
module xpb_next_digit #(
    parameter int N = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             empty
);

    // Scan from the top down so the lowest set bit is the one that sticks
    always_comb begin
        idx   = '0;
        empty = (mask == '0);
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/xpb_reduce_sched.sv
// Sequential reduction scheduler: issues one xpb ROM lookup per reduction
// digit, accumulates the returned entries into a widened sum and hands the
// result downstream over valid/ready.
// Optional feature: define XPB_SKIP_ZERO_EN to skip lookups for zero digits
// (entry 0 of every table is zero, so skipping them does not change the sum).
module xpb_reduce_sched
    import xpb_sched_pkg::*;
#(
    parameter int NUM_DIGITS = 16,
    parameter int ROM_LAT    = 1,
    localparam int SEL_W     = $clog2(NUM_DIGITS),
    localparam int ACC_W     = acc_w(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] in_digits,
    output logic                          rom_en,
    output logic [SEL_W-1:0]              rom_sel,
    output logic [DIGIT_W-1:0]            rom_idx,
    input  logic [WORD_W-1:0]             rom_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_sum,
    output logic                          busy
);

    state_t                        state_q, state_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
    logic                          rom_en_q, rom_en_d;
    logic [SEL_W-1:0]              rom_sel_q, rom_sel_d;
    logic [DIGIT_W-1:0]            rom_idx_q, rom_idx_d;
    logic [ROM_LAT-1:0]            vpipe_q, vpipe_d;
    logic [ACC_W-1:0]              acc_q, acc_d;
    logic                          out_valid_q, out_valid_d;
    logic                          in_ready_q, in_ready_d;
    logic                          busy_q, busy_d;

`ifdef XPB_SKIP_ZERO_EN
    logic [NUM_DIGITS-1:0]         mask_q, mask_d;
    logic [NUM_DIGITS-1:0]         new_mask;
    logic [NUM_DIGITS-1:0]         enc_mask;
    logic [SEL_W-1:0]              enc_idx;
    logic                          enc_empty;

    // One digit is nonzero-flagged per position; IDLE looks at the incoming
    // job, ISSUE at what is still left of the latched one
    always_comb begin
        new_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            new_mask[i] = |in_digits[i*DIGIT_W +: DIGIT_W];
        end
        enc_mask = (state_q == IDLE) ? new_mask : mask_q;
    end

    xpb_next_digit #(
        .N(NUM_DIGITS)
    ) u_next_digit (
        .mask  (enc_mask),
        .idx   (enc_idx),
        .empty (enc_empty)
    );
`else
    logic [SEL_W-1:0]              next_sel;
`endif

    // Next-state logic: FSM, in-flight tracking pipe and accumulator
    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        rom_en_d    = 1'b0;
        rom_sel_d   = rom_sel_q;
        rom_idx_d   = rom_idx_q;
        out_valid_d = out_valid_q;
`ifdef XPB_SKIP_ZERO_EN
        mask_d      = mask_q;
`else
        next_sel    = rom_sel_q + SEL_W'(1);
`endif

        vpipe_d    = '0;
        vpipe_d[0] = rom_en_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        acc_d = acc_q;
        if (vpipe_q[ROM_LAT-1]) begin
            acc_d = acc_q + ACC_W'(rom_data);
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    digits_d = in_digits;
                    acc_d    = '0;
`ifdef XPB_SKIP_ZERO_EN
                    if (enc_empty) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d           = ISSUE;
                        rom_en_d          = 1'b1;
                        rom_sel_d         = enc_idx;
                        rom_idx_d         = in_digits[int'(enc_idx)*DIGIT_W +: DIGIT_W];
                        mask_d            = new_mask;
                        mask_d[enc_idx]   = 1'b0;
                    end
`else
                    state_d   = ISSUE;
                    rom_en_d  = 1'b1;
                    rom_sel_d = '0;
                    rom_idx_d = in_digits[DIGIT_W-1:0];
`endif
                end
            end
            ISSUE: begin
`ifdef XPB_SKIP_ZERO_EN
                if (enc_empty) begin
                    state_d = DRAIN;
                end else begin
                    rom_en_d        = 1'b1;
                    rom_sel_d       = enc_idx;
                    rom_idx_d       = digits_q[int'(enc_idx)*DIGIT_W +: DIGIT_W];
                    mask_d[enc_idx] = 1'b0;
                end
`else
                if (rom_sel_q == SEL_W'(NUM_DIGITS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    rom_en_d  = 1'b1;
                    rom_sel_d = next_sel;
                    rom_idx_d = digits_q[int'(next_sel)*DIGIT_W +: DIGIT_W];
                end
`endif
            end
            DRAIN: begin
                if (vpipe_d == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and registered outputs; reset discards any job in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            rom_en_q    <= 1'b0;
            rom_sel_q   <= '0;
            rom_idx_q   <= '0;
            vpipe_q     <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef XPB_SKIP_ZERO_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            rom_en_q    <= rom_en_d;
            rom_sel_q   <= rom_sel_d;
            rom_idx_q   <= rom_idx_d;
            vpipe_q     <= vpipe_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef XPB_SKIP_ZERO_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_en    = rom_en_q;
    assign rom_sel   = rom_sel_q;
    assign rom_idx   = rom_idx_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_xpb_reduce_sched.sv
// Testbench for xpb_reduce_sched with NUM_DIGITS=4, ROM_LAT=1 and a
// behavioural ROM: T_k[0] = 0, T_k[i] = (k+1)*2^1000 + i otherwise.
// Expected latencies follow XPB_SKIP_ZERO_EN when it is defined.
module tb_xpb_reduce_sched;

    localparam int NUM_D = 4;
    localparam int ACC_W = 1026;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [19:0]       in_digits;
    logic              rom_en;
    logic [1:0]        rom_sel;
    logic [4:0]        rom_idx;
    logic [1023:0]     rom_data = '0;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              busy;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit ignore_issue = 1'b0;

    typedef struct {
        logic [19:0] digits;
        int          hi;
        int          lo;
        int          lat_full;
        int          lat_skip;
    } vec_t;

    typedef struct {
        logic [ACC_W-1:0] sum;
        int               at_cyc;
    } out_exp_t;

    typedef struct {
        int at_cyc;
        int sel;
        int idx;
    } iss_exp_t;

    out_exp_t sb_q[$];
    iss_exp_t iss_q[$];
    vec_t     vecs[6];

    xpb_reduce_sched #(
        .NUM_DIGITS(NUM_D),
        .ROM_LAT   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digits (in_digits),
        .rom_en    (rom_en),
        .rom_sel   (rom_sel),
        .rom_idx   (rom_idx),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    // Free-running clock and cycle counter
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [ACC_W-1:0] mk_sum(input int hi, input int lo);
        logic [ACC_W-1:0] r;
        r = ACC_W'(hi);
        r = r << 1000;
        r = r + ACC_W'(lo);
        return r;
    endfunction

    function automatic logic [1023:0] rom_entry(input logic [1:0] sel, input logic [4:0] idx);
        logic [1023:0] r;
        if (idx == 5'd0) return '0;
        r = 1024'(int'(sel) + 1);
        r = r << 1000;
        r = r + 1024'(idx);
        return r;
    endfunction

    // Behavioural ROM with one cycle of read latency
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_entry(rom_sel, rom_idx);
    end

    task automatic check_output(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_sum(input string name, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue monitor: every lookup must match the next expected (cycle, sel, idx)
    always @(negedge clk) begin
        iss_exp_t e;
        if (rom_en && !ignore_issue) begin
            if (iss_q.size() == 0) begin
                check_output("unexpected_rom_en_cycle", cyc, -1);
            end else begin
                e = iss_q.pop_front();
                check_output("issue_cycle", cyc, e.at_cyc);
                check_output("issue_sel", rom_sel, e.sel);
                check_output("issue_idx", rom_idx, e.idx);
            end
        end
    end

    // Output monitor: each handshake pops one scoreboard entry
    always @(negedge clk) begin
        out_exp_t e;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_output_cycle", cyc, -1);
            end else begin
                e = sb_q.pop_front();
                check_sum("out_sum", out_sum, e.sum);
                check_output("handshake_cycle", cyc, e.at_cyc);
            end
        end
    end

    // Start one job; returns during the cycle after acceptance
    task automatic apply_stimulus(input logic [19:0] digits, input int hi, input int lo,
                                  input int lat, input int extra, input bit push,
                                  output int acc_cyc);
        int j;
        logic [4:0] d;
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        if (!seen) check_output("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_digits = digits;
        @(negedge clk);
        acc_cyc = cyc;
        if (push) begin
            sb_q.push_back('{sum: mk_sum(hi, lo), at_cyc: acc_cyc + lat + extra});
            j = 0;
            for (int k = 0; k < NUM_D; k++) begin
                d = digits[k*5 +: 5];
`ifdef XPB_SKIP_ZERO_EN
                if (d != 5'd0) begin
                    iss_q.push_back('{at_cyc: acc_cyc + 1 + j, sel: k, idx: int'(d)});
                    j++;
                end
`else
                iss_q.push_back('{at_cyc: acc_cyc + 1 + k, sel: k, idx: int'(d)});
`endif
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_digits = 20'($urandom);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && iss_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check_output("job_timeout_pending", sb_q.size() + iss_q.size(), 0);
            sb_q.delete();
            iss_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_in_ready"}, in_ready, 1);
        check_output({tag, "_rom_en"}, rom_en, 0);
        check_output({tag, "_rom_sel"}, rom_sel, 0);
        check_output({tag, "_rom_idx"}, rom_idx, 0);
        check_output({tag, "_out_valid"}, out_valid, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_sum({tag, "_out_sum"}, out_sum, '0);
    endtask

    function automatic int pick_lat(input vec_t v);
`ifdef XPB_SKIP_ZERO_EN
        return v.lat_skip;
`else
        return v.lat_full;
`endif
    endfunction

    initial begin
        int a;
        int lat;
        bit seen;

        vecs[0] = '{digits: {5'd1,  5'd1,  5'd1,  5'd1},  hi: 10, lo: 4,   lat_full: 6, lat_skip: 6};
        vecs[1] = '{digits: {5'd31, 5'd31, 5'd31, 5'd31}, hi: 10, lo: 124, lat_full: 6, lat_skip: 6};
        vecs[2] = '{digits: {5'd7,  5'd0,  5'd3,  5'd0},  hi: 6,  lo: 10,  lat_full: 6, lat_skip: 4};
        vecs[3] = '{digits: {5'd0,  5'd0,  5'd0,  5'd0},  hi: 0,  lo: 0,   lat_full: 6, lat_skip: 1};
        vecs[4] = '{digits: {5'd0,  5'd0,  5'd0,  5'd2},  hi: 1,  lo: 2,   lat_full: 6, lat_skip: 3};
        vecs[5] = '{digits: {5'd0,  5'd9,  5'd0,  5'd5},  hi: 4,  lo: 14,  lat_full: 6, lat_skip: 4};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_digits = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table-driven jobs with out_ready held high
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].digits, vecs[i].hi, vecs[i].lo, pick_lat(vecs[i]), 0, 1'b1, a);
            wait_done();
        end

        // Back-pressure: out_ready low for 10 cycles of valid output
        out_ready = 1'b0;
        apply_stimulus(vecs[0].digits, 10, 4, 6, 10, 1'b1, a);
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_output("bp_first_valid_cycle", cyc, a + 6);
        for (int i = 0; i < 10; i++) begin
            check_sum("bp_sum_stable", out_sum, mk_sum(10, 4));
            check_output("bp_out_valid", out_valid, 1);
            check_output("bp_in_ready", in_ready, 0);
            check_output("bp_rom_en", rom_en, 0);
            if (i < 9) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("bp_in_ready_after", in_ready, 1);
        check_output("bp_out_valid_after", out_valid, 0);
        wait_done();

        // Reset pulsed in cycle 2 of a job, then a clean job
        ignore_issue = 1'b1;
        apply_stimulus(vecs[1].digits, 0, 0, 0, 0, 1'b0, a);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midjob_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("after_reset");
        ignore_issue = 1'b0;
        lat = pick_lat(vecs[4]);
        apply_stimulus(vecs[4].digits, 1, 2, lat, 0, 1'b1, a);
        wait_done();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xpb_reduce_sched.md
# xpb_reduce_sched

Sequential reduction scheduler for the modular-squaring datapath. Accepts a packed vector of 5-bit reduction digits and, for each digit k, issues one lookup (table select k, index = digit) into the shared xpb ROM bank. It accumulates the returned 1024-bit entries into a widened sum and hands the result downstream over a valid/ready interface. It sits between the squarer's upper-word split and the final reduction adder, and is the only master of the ROM bank.

## Interface
- NUM_DIGITS, 16, number of 5-bit digits (and xpb tables) per job; 2..64
- ROM_LAT, 1, ROM read latency in cycles, from rom_en to rom_data; 1..3
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  job request
- in_ready  out  1  high only in IDLE; reset value 1
- in_digits  in  NUM_DIGITS*5  digit k at bits [5k+4:5k]
- rom_en  out  1  lookup strobe; reset value 0
- rom_sel  out  $clog2(NUM_DIGITS)  table select (= k); reset value 0
- rom_idx  out  5  table index (= digit k); reset value 0
- rom_data  in  1024  entry, valid ROM_LAT cycles after rom_en
- out_valid  out  1  result valid; reset value 0
- out_ready  in  1  downstream accept
- out_sum  out  ACC_W = 1024+$clog2(NUM_DIGITS)  accumulated sum; reset value 0
- busy  out  1  state != IDLE; reset value 0

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on in_valid && in_ready, latch in_digits, clear the accumulator, set k=0, and go to ISSUE.
- ISSUE: each cycle assert rom_en with rom_sel=k and rom_idx=digit k, then advance k. After the last digit is issued, go to DRAIN.
- ROM_LAT-deep valid shift register tracks in-flight lookups. When its tail is set: sum <= sum + zero-extended rom_data.
- DRAIN: wait until the shift register is empty, then go to DONE.
- DONE: out_valid=1 and out_sum=accumulator, both held stable until out_ready. On the handshake, go to IDLE.
- No new job is accepted in the same cycle as the output handshake.
- Accumulator width ACC_W guarantees no overflow. No modular wrap is applied here.
- Reset mid-job: all state is discarded immediately. The in-flight ROM responses are ignored because the valid pipe is cleared. The next cycle after deassertion is IDLE.
- in_digits is sampled only at acceptance; later changes to it are ignored.

## Timing
- Acceptance cycle = 0. Issues occur in cycles 1..NUM_DIGITS.
- Last accumulate happens at the edge ending cycle NUM_DIGITS+ROM_LAT.
- out_valid asserts in cycle NUM_DIGITS+ROM_LAT+1 (skip disabled).
- Throughput: one job per NUM_DIGITS+ROM_LAT+2 cycles minimum, with out_ready held high.
- rom_en is never high outside ISSUE.

## Configuration
- XPB_SKIP_ZERO_EN defined:
  - Digits equal to 0 are not issued; entry 0 is defined zero.
  - ISSUE jumps k to the next nonzero digit via a priority encoder over the remaining-digit mask.
  - With Z nonzero digits (Z>0), out_valid asserts in cycle Z+ROM_LAT+1.
  - An all-zero job goes IDLE->DONE directly, with out_valid in cycle 1 and out_sum=0.
- Undefined: every digit is issued, including zeros, and latency is fixed as given under Timing.

## Structure
- Package xpb_sched_pkg holds:
  - DIGIT_W=5 and WORD_W=1024
  - the state enum
  - an ACC_W helper function
- Sub-module xpb_next_digit: combinational priority encoder. Input is the remaining mask; outputs are the next index and an empty flag. It is used only under XPB_SKIP_ZERO_EN.

## Test plan
- Bench setup: NUM_DIGITS=4, ROM_LAT=1, behavioural ROM returning T_k[i] = (k+1)*2^1000 + i.
- Digits {1,1,1,1}, skip off -> out_valid at cycle 6; out_sum = 10*2^1000 + 4; rom_sel sequence 0,1,2,3 on cycles 1-4.
- Digits {31,31,31,31} -> out_sum = 10*2^1000 + 124; no bits lost.
- Skip on, digits {0,3,0,7}:
  - rom_en only on cycles 1-2, with sel/idx (1,3) then (3,7).
  - out_valid at cycle 4; out_sum = 6*2^1000 + 10.
- All-zero digits:
  - Skip on: out_valid at cycle 1, out_sum=0, rom_en never high.
  - Skip off: out_valid at cycle 6, out_sum=0.
- Back-pressure: out_ready low for 10 cycles -> out_sum stable, in_ready=0, rom_en=0; release gives one handshake, then in_ready=1 the next cycle.
- reset pulsed in cycle 2 of a job -> all outputs return to reset values. A new job {2,0,0,0} then yields out_sum = 1*2^1000 + 2 with no contamination from the aborted job.
